// File: rtl/rbm_pkg.sv
// Shared widths, shift amounts and FSM encodings for the RBM backward-pass core.
package rbm_pkg;

  localparam int H_W        = 16;               // hidden probability, unsigned Q0.16
  localparam int W_W        = 16;               // weight, signed Q1.15
  localparam int X_W        = 16;               // sigmoid input, signed, 11 fractional bits
  localparam int V_W        = 16;               // visible probability, unsigned Q0.16
  localparam int P_W        = H_W + 1 + W_W;    // product, signed Q1.31
  localparam int PROD_SHIFT = 16;               // Q1.31 -> Q1.15
  localparam int X_SHIFT    = 4;                // Q16.15 -> 11 fractional bits
  // x is clipped to +/-8.0; beyond that the sigmoid is flat to the output LSB.
  localparam int X_LIM      = 16384;

  typedef logic [2:0] state_t;

  localparam state_t S_IDLE  = 3'd0;
  localparam state_t S_MAC   = 3'd1;
  localparam state_t S_DRAIN = 3'd2;
  localparam state_t S_SAT   = 3'd3;
  localparam state_t S_LUT   = 3'd4;
  localparam state_t S_OUT   = 3'd5;

endpackage

// File: rtl/sigmoid_lut.sv
// Registered piecewise-linear sigmoid: signed input with 11 fractional bits, Q0.16 output.
// One cycle latency, no flow control; the output follows the input every cycle.
module sigmoid_lut
  import rbm_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic signed [X_W-1:0] x,
  output logic        [V_W-1:0] y
);

  logic [15:0]    ax;
  logic [17:0]    yp;
  logic [17:0]    ys;
  logic [V_W-1:0] y_nxt;

  // Segments evaluated on |x| in Q.16 units, then mirrored as 1 - y for negative x.
  always_comb begin
    ax = x[X_W-1] ? 16'(-x) : 16'(x);
    if (ax < 16'd2048)
      yp = {ax, 2'b00} * 18'd2 + 18'd32768;
    else if (ax < 16'd4864)
      yp = {2'b00, ax} * 18'd4 + 18'd40960;
    else if (ax < 16'd10240)
      yp = {2'b00, ax} + 18'd55296;
    else
      yp = 18'd65536;
    ys    = x[X_W-1] ? (18'd65536 - yp) : yp;
    y_nxt = (ys >= 18'd65536) ? 16'hFFFF : ys[15:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) y <= '0;
    else        y <= y_nxt;
  end

endmodule

// File: rtl/rbm_core_bwd.sv
// Reconstructs one visible unit: v = sigmoid(a_i + sum_j h_j * w_ij), saturating throughout.
// Result at edge H_DIM+4 after start; held in OUT until v_ready, start ignored unless idle.
module rbm_core_bwd
  import rbm_pkg::*;
#(
  parameter int H_DIM = 64,
  parameter int ACC_W = 32
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  output logic                    busy,
  input  logic        [H_W-1:0]   h_vec [H_DIM],
  input  logic        [W_W-1:0]   w_row [H_DIM],
  input  logic signed [ACC_W-1:0] a_i,
  output logic        [V_W-1:0]   v_i,
  output logic                    v_valid,
  input  logic                    v_ready,
  output logic                    sat
);

  localparam int IDX_W = (H_DIM > 1) ? $clog2(H_DIM) : 1;
  localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};
  localparam logic signed [ACC_W-1:0] XC_HI   = ACC_W'(X_LIM - 1);
  localparam logic signed [ACC_W-1:0] XC_LO   = ACC_W'(-X_LIM);

  state_t                  state;
  logic        [IDX_W-1:0] idx;
  logic signed [P_W-1:0]   prod;
  logic signed [P_W-1:0]   prod_nxt;
  logic                    prod_vld;
  logic signed [ACC_W-1:0] acc;
  logic signed [ACC_W-1:0] acc_nxt;
  logic signed [ACC_W-1:0] addend;
  logic        [ACC_W:0]   sum;
  logic                    ovf;
  logic signed [ACC_W-1:0] acc_sh;
  logic signed [X_W-1:0]   x_nxt;
  logic                    x_clip;
  logic signed [X_W-1:0]   x_q;
  logic                    sat_flag;
  logic                    lut_wait;
  logic        [V_W-1:0]   lut_y;

  assign prod_nxt = $signed({1'b0, h_vec[idx]}) * $signed(w_row[idx]);
  assign addend   = ACC_W'(prod >>> PROD_SHIFT);

  // One extra sign bit exposes overflow so the sum clamps instead of wrapping.
  assign sum     = {acc[ACC_W-1], acc} + {addend[ACC_W-1], addend};
  assign ovf     = sum[ACC_W] ^ sum[ACC_W-1];
  assign acc_nxt = ovf ? (sum[ACC_W] ? ACC_MIN : ACC_MAX) : sum[ACC_W-1:0];
  assign acc_sh  = acc >>> X_SHIFT;

  always_comb begin
    x_clip = 1'b1;
    if (acc_sh > XC_HI)      x_nxt = X_W'(XC_HI);
    else if (acc_sh < XC_LO) x_nxt = X_W'(XC_LO);
    else begin
      x_nxt  = acc_sh[X_W-1:0];
      x_clip = 1'b0;
    end
  end

  assign busy = (state != S_IDLE);

  sigmoid_lut u_sigmoid (
    .clk   (clk),
    .rst_n (rst_n),
    .x     (x_q),
    .y     (lut_y)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      idx      <= '0;
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
      x_q      <= '0;
      sat_flag <= 1'b0;
      lut_wait <= 1'b0;
      v_i      <= '0;
      v_valid  <= 1'b0;
      sat      <= 1'b0;
    end else begin
      prod     <= prod_nxt;
      prod_vld <= (state == S_MAC);
      case (state)
        S_IDLE: if (start) begin
          acc      <= a_i;
          idx      <= '0;
          sat_flag <= 1'b0;
          state    <= S_MAC;
        end
        S_MAC, S_DRAIN: begin
          if (prod_vld) begin
            acc <= acc_nxt;
            if (ovf) sat_flag <= 1'b1;
          end
          if (state == S_DRAIN) state <= S_SAT;
          else begin
            idx <= idx + 1'b1;
            if (idx == IDX_W'(H_DIM - 1)) state <= S_DRAIN;
          end
        end
        S_SAT: begin
          x_q      <= x_nxt;
          sat_flag <= sat_flag | x_clip;
          lut_wait <= 1'b1;
          state    <= S_LUT;
        end
        // First LUT cycle lets the sigmoid register sample x_q; the second captures it.
        S_LUT: begin
          lut_wait <= 1'b0;
          if (!lut_wait) begin
            v_i     <= lut_y;
            sat     <= sat_flag;
            v_valid <= 1'b1;
            state   <= S_OUT;
          end
        end
        S_OUT: if (v_ready) begin
          v_valid <= 1'b0;
          state   <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
